// File: rtl/frontier_bitmap_scanner.sv
// frontier_bitmap_scanner: per-core active-vertex front end.
// Keeps a ping-pong visited bitmap (current frontier plus next frontier written
// by the backend). It scans the current bank word by word through a bounded
// prefetch queue, emits global vertex IDs on a valid/ready stream, and runs the
// per-iteration end handshake with the backend.
// Optional macro FRONTIER_COUNT_EN adds a per-iteration accepted-ID counter port.
module frontier_bitmap_scanner #(
  parameter int V_ID_WIDTH      = 20,
  parameter int ITERATION_WIDTH = 8,
  parameter int CORE_ID         = 0,
  parameter int CORE_NUM_WIDTH  = 5,
  parameter int WORD_WIDTH      = 32,
  parameter int WORD_ADDR_WIDTH = 6,
  parameter int PREFETCH_DEPTH  = 4,
  parameter int READ_LATENCY    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                vertex_num,
  input  logic [31:0]                iteration_num,
  input  logic                       upd_valid,
  input  logic [V_ID_WIDTH-1:0]      upd_v_id,
  input  logic                       upd_set,
  output logic [V_ID_WIDTH-1:0]      out_v_id,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       iteration_end,
  input  logic                       backend_iteration_end_valid,
  input  logic [ITERATION_WIDTH-1:0] backend_iteration_id,
  output logic [ITERATION_WIDTH-1:0] iteration_id,
  output logic                       iteration_done
`ifdef FRONTIER_COUNT_EN
  ,
  output logic [V_ID_WIDTH-1:0]      frontier_count
`endif
);

  localparam int BIT_W = $clog2(WORD_WIDTH);
  localparam int DEPTH = 1 << WORD_ADDR_WIDTH;
  localparam int PTR_W = $clog2(PREFETCH_DEPTH);
  localparam int CNT_W = $clog2(PREFETCH_DEPTH + 1);
  localparam int SHIFT = BIT_W + CORE_NUM_WIDTH;
  localparam logic [31:0] VERTS_PER_WORD = 32'(WORD_WIDTH) << CORE_NUM_WIDTH;
  localparam logic [31:0] CORE_ID_EXT =
    32'(CORE_ID) & ((32'd1 << CORE_NUM_WIDTH) - 32'd1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(PREFETCH_DEPTH - 1);

  localparam logic [1:0] ST_INIT     = 2'd0;
  localparam logic [1:0] ST_SCAN     = 2'd1;
  localparam logic [1:0] ST_WAIT_END = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  logic [1:0]                 state;
  // Shared pointer: bank write address during INIT, read-issue address in SCAN.
  logic [WORD_ADDR_WIDTH:0]   addr;
  logic [WORD_ADDR_WIDTH-1:0] addr_idx;
  logic [31:0]                words_num;
  logic                       addr_at_end;
  logic                       cur_bank;
  logic                       nxt_bank;

  logic [WORD_WIDTH-1:0]      bank [2][DEPTH];

  logic [READ_LATENCY-1:0]    pipe_valid;
  logic [WORD_WIDTH-1:0]      pipe_word [READ_LATENCY];
  logic [WORD_ADDR_WIDTH-1:0] pipe_addr [READ_LATENCY];

  logic [WORD_WIDTH-1:0]      q_word [PREFETCH_DEPTH];
  logic [WORD_ADDR_WIDTH-1:0] q_addr [PREFETCH_DEPTH];
  logic [PTR_W-1:0]           q_head;
  logic [PTR_W-1:0]           q_tail;
  logic [CNT_W-1:0]           q_count;

  logic                       hold_valid;
  logic [WORD_WIDTH-1:0]      hold_word;
  logic [WORD_ADDR_WIDTH-1:0] hold_addr;
  logic [BIT_W-1:0]           lsb;
  logic                       hold_nonzero;
  logic [31:0]                cand_id;
  logic                       in_range;

  logic                       issue_en;
  logic                       push;
  logic                       pop;
  logic                       scan_complete;
  logic                       end_ack;
  logic [ITERATION_WIDTH-1:0] next_iter;

  logic [31:0]                upd_bit_idx;
  logic                       upd_write;
  logic [WORD_ADDR_WIDTH-1:0] upd_word;
  logic [BIT_W-1:0]           upd_bit;

  assign words_num   = (vertex_num + VERTS_PER_WORD - 32'd1) >> SHIFT;
  assign addr_idx    = addr[WORD_ADDR_WIDTH-1:0];
  assign addr_at_end = (32'(addr) >= words_num);
  assign cur_bank    = iteration_id[0];
  assign nxt_bank    = ~iteration_id[0];

  // Reads are gated by in-flight plus queued words so the queue cannot overflow.
  assign issue_en = (state == ST_SCAN) && !addr_at_end &&
                    (($countones(pipe_valid) + int'(q_count)) < PREFETCH_DEPTH);
  assign push     = pipe_valid[READ_LATENCY-1];
  assign pop      = (state == ST_SCAN) && !hold_valid && (q_count != '0);

  assign scan_complete = (state == ST_SCAN) && addr_at_end && (pipe_valid == '0) &&
                         (q_count == '0) && !hold_valid;
  assign end_ack   = (state == ST_WAIT_END) && backend_iteration_end_valid &&
                     (backend_iteration_id == iteration_id);
  assign next_iter = iteration_id + 1'b1;

  assign upd_bit_idx = 32'(upd_v_id) >> CORE_NUM_WIDTH;
  assign upd_write   = upd_valid && (state != ST_INIT) &&
                       (upd_bit_idx < (words_num << BIT_W));
  assign upd_word    = upd_bit_idx[BIT_W +: WORD_ADDR_WIDTH];
  assign upd_bit     = upd_bit_idx[BIT_W-1:0];

  // Lowest set bit of the holding word selects the next candidate vertex.
  always_comb begin
    // NOTE: default first so every path assigns lsb and no latch is inferred.
    lsb = '0;
    for (int i = WORD_WIDTH - 1; i >= 0; i--) begin
      if (hold_word[i]) lsb = BIT_W'(i);
    end
  end

  assign hold_nonzero = |hold_word;
  assign cand_id  = (((32'(hold_addr) << BIT_W) | 32'(lsb)) << CORE_NUM_WIDTH) | CORE_ID_EXT;
  assign in_range = (cand_id < vertex_num);

  // Outputs come straight from registered holding state, never from out_ready.
  assign out_valid = (state == ST_SCAN) && hold_valid && hold_nonzero && in_range;
  assign out_v_id  = out_valid ? cand_id[V_ID_WIDTH-1:0] : '0;

  // Bitmap banks, read pipeline data and queue storage (datapath only).
  // NOTE: RAM and queue payload carry no reset; INIT rewrites every live word and
  // the reset valid flags keep stale payload from ever being used.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT && words_num != 32'd0) begin
        bank[0][addr_idx] <= '1;
        bank[1][addr_idx] <= '0;
      end
      if (pop)       bank[cur_bank][q_addr[q_head]] <= '0;
      if (upd_write) bank[nxt_bank][upd_word][upd_bit] <= upd_set;
    end
    pipe_word[0] <= bank[cur_bank][addr_idx];
    pipe_addr[0] <= addr_idx;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_word[i] <= pipe_word[i-1];
      pipe_addr[i] <= pipe_addr[i-1];
    end
    if (push) begin
      q_word[q_tail] <= pipe_word[READ_LATENCY-1];
      q_addr[q_tail] <= pipe_addr[READ_LATENCY-1];
    end
  end

  // Read-latency valid pipeline; reset drops every in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= issue_en;
      for (int i = 1; i < READ_LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
    end
  end

  // Prefetch queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_head  <= '0;
      q_tail  <= '0;
      q_count <= '0;
    end else begin
      if (push) q_tail <= (q_tail == PTR_LAST) ? '0 : q_tail + 1'b1;
      if (pop)  q_head <= (q_head == PTR_LAST) ? '0 : q_head + 1'b1;
      case ({push, pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: q_count <= q_count;
      endcase
    end
  end

  // Holding register: load from queue head, retire one bit per accept or skip.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_word  <= '0;
      hold_addr  <= '0;
    end else if (pop) begin
      hold_valid <= 1'b1;
      hold_word  <= q_word[q_head];
      hold_addr  <= q_addr[q_head];
    end else if (hold_valid) begin
      if (!hold_nonzero)              hold_valid     <= 1'b0;
      else if (!in_range || out_ready) hold_word[lsb] <= 1'b0;
    end
  end

  // Top-level sequencing: INIT -> SCAN -> WAIT_END -> (SCAN | DONE).
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_INIT;
      addr           <= '0;
      iteration_id   <= '0;
      iteration_end  <= 1'b0;
      iteration_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (words_num == 32'd0 || 32'(addr) == words_num - 32'd1) begin
            addr <= '0;
            if (iteration_num == 32'd0) begin
              state          <= ST_DONE;
              iteration_done <= 1'b1;
            end else begin
              state <= ST_SCAN;
            end
          end else begin
            addr <= addr + 1'b1;
          end
        end
        ST_SCAN: begin
          if (issue_en) addr <= addr + 1'b1;
          if (scan_complete) begin
            state         <= ST_WAIT_END;
            iteration_end <= 1'b1;
          end
        end
        ST_WAIT_END: begin
          if (end_ack) begin
            iteration_id  <= next_iter;
            iteration_end <= 1'b0;
            addr          <= '0;
            if (32'(next_iter) == iteration_num) begin
              state          <= ST_DONE;
              iteration_done <= 1'b1;
            end else begin
              state <= ST_SCAN;
            end
          end
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_INIT;
      endcase
    end
  end

`ifdef FRONTIER_COUNT_EN
  // Accepted-ID count for the current iteration; cleared on the iteration switch.
  always_ff @(posedge clk) begin
    if (rst)                        frontier_count <= '0;
    else if (end_ack)               frontier_count <= '0;
    else if (out_valid && out_ready) frontier_count <= frontier_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_frontier_bitmap_scanner.sv
// Testbench for frontier_bitmap_scanner. The reference model keeps the current
// and next frontier as plain per-bit arrays and derives the expected ID list.
module tb_frontier_bitmap_scanner;

  localparam int VW   = 20;
  localparam int ITW  = 8;
  localparam int CID  = 1;
  localparam int CNW  = 2;
  localparam int WW   = 8;
  localparam int WAW  = 6;
  localparam int PD   = 4;
  localparam int RL   = 2;
  localparam int VPW  = WW << CNW;
  localparam int MAXB = (1 << WAW) * WW;

  logic           clk = 1'b0;
  logic           rst;
  logic [31:0]    vertex_num;
  logic [31:0]    iteration_num;
  logic           upd_valid;
  logic [VW-1:0]  upd_v_id;
  logic           upd_set;
  logic [VW-1:0]  out_v_id;
  logic           out_valid;
  logic           out_ready;
  logic           iteration_end;
  logic           backend_iteration_end_valid;
  logic [ITW-1:0] backend_iteration_id;
  logic [ITW-1:0] iteration_id;
  logic           iteration_done;
`ifdef FRONTIER_COUNT_EN
  logic [VW-1:0]  frontier_count;
`endif

  always #5 clk = ~clk;

  frontier_bitmap_scanner #(
    .V_ID_WIDTH(VW), .ITERATION_WIDTH(ITW), .CORE_ID(CID), .CORE_NUM_WIDTH(CNW),
    .WORD_WIDTH(WW), .WORD_ADDR_WIDTH(WAW), .PREFETCH_DEPTH(PD), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst(rst), .vertex_num(vertex_num), .iteration_num(iteration_num),
    .upd_valid(upd_valid), .upd_v_id(upd_v_id), .upd_set(upd_set),
    .out_v_id(out_v_id), .out_valid(out_valid), .out_ready(out_ready),
    .iteration_end(iteration_end),
    .backend_iteration_end_valid(backend_iteration_end_valid),
    .backend_iteration_id(backend_iteration_id),
    .iteration_id(iteration_id), .iteration_done(iteration_done)
`ifdef FRONTIER_COUNT_EN
    , .frontier_count(frontier_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  bit m_cur [MAXB];
  bit m_nxt [MAXB];
  int m_vn;
  int m_words;
  int exp_q [$];
  int got_q [$];

  function automatic void model_init(int vn);
    m_vn    = vn;
    m_words = (vn + VPW - 1) / VPW;
    for (int j = 0; j < MAXB; j++) begin
      m_cur[j] = (j < m_words * WW);
      m_nxt[j] = 1'b0;
    end
  endfunction

  function automatic void model_update(int id, bit s);
    int j;
    j = id >> CNW;
    if (j < m_words * WW) m_nxt[j] = s;
  endfunction

  function automatic void model_switch();
    for (int j = 0; j < MAXB; j++) begin
      m_cur[j] = m_nxt[j];
      m_nxt[j] = 1'b0;
    end
  endfunction

  function automatic void model_expect();
    int id;
    exp_q.delete();
    for (int j = 0; j < m_words * WW; j++) begin
      id = (j << CNW) | CID;
      if (m_cur[j] && id < m_vn) exp_q.push_back(id);
    end
  endfunction

  task automatic wait_init();
    repeat (m_words + 1) @(negedge clk);
  endtask

  task automatic do_reset(input int vn, input int itn);
    @(negedge clk);
    rst = 1'b1;
    vertex_num = 32'(vn);
    iteration_num = 32'(itn);
    upd_valid = 1'b0;
    backend_iteration_end_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_init(vn);
    wait_init();
  endtask

  task automatic drive_upd(input int id, input bit s);
    upd_valid = 1'b1;
    upd_v_id  = VW'(id);
    upd_set   = s;
    model_update(id, s);
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  task automatic send_end(input int id);
    backend_iteration_end_valid = 1'b1;
    backend_iteration_id = ITW'(id);
    @(negedge clk);
    backend_iteration_end_valid = 1'b0;
  endtask

  // Runs until iteration_end, collecting accepted IDs and checking handshake stability.
  task automatic run_iteration(input bit rand_ready, input bit rand_upd, input string tag);
    bit           prev_valid = 1'b0;
    bit           prev_ready = 1'b0;
    logic [VW-1:0] prev_id = '0;
    int           cycles = 0;
    int           id;
    bit           s;
    got_q.delete();
    model_expect();
    forever begin
      @(negedge clk);
      cycles++;
      if (prev_valid && !prev_ready) begin
        checks++;
        if (out_valid !== 1'b1 || out_v_id !== prev_id) begin
          errors++;
          $display("FAIL %s_stable: got valid=%0b id=%0d expected valid=1 id=%0d",
                   tag, out_valid, out_v_id, prev_id);
        end
      end
      if (iteration_end === 1'b1) begin
        upd_valid = 1'b0;
        break;
      end
      if (cycles > 3000) begin
        checks++;
        errors++;
        upd_valid = 1'b0;
        $display("FAIL %s_timeout: got no iteration_end expected iteration_end=1", tag);
        break;
      end
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      upd_valid = 1'b0;
      if (rand_upd && $urandom_range(0, 2) == 0) begin
        id = int'($urandom_range(0, m_vn + 40));
        s  = 1'($urandom_range(0, 1));
        upd_valid = 1'b1;
        upd_v_id  = VW'(id);
        upd_set   = s;
        model_update(id, s);
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) got_q.push_back(int'(out_v_id));
      prev_valid = (out_valid === 1'b1);
      prev_ready = out_ready;
      prev_id    = out_v_id;
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d ids expected %0d", tag, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] != exp_q[i]) begin
        errors++;
        $display("FAIL %s_id[%0d]: got %0d expected %0d", tag, i, got_q[i], exp_q[i]);
      end
    end
`ifdef FRONTIER_COUNT_EN
    checks++;
    if (frontier_count !== VW'(got_q.size())) begin
      errors++;
      $display("FAIL %s_frontier_count: got %0d expected %0d", tag, frontier_count, got_q.size());
    end
`endif
  endtask

  task automatic check_iter(input string tag, input int exp_id, input bit exp_end);
    checks++;
    if (iteration_id !== ITW'(exp_id) || iteration_end !== exp_end) begin
      errors++;
      $display("FAIL %s: got iteration_id=%0d iteration_end=%0b expected %0d/%0b",
               tag, iteration_id, iteration_end, exp_id, exp_end);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vertex_num = 32'd20;
    iteration_num = 32'd3;
    upd_valid = 1'b0;
    upd_v_id = '0;
    upd_set = 1'b0;
    out_ready = 1'b1;
    backend_iteration_end_valid = 1'b0;
    backend_iteration_id = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_v_id !== '0 || iteration_end !== 1'b0 ||
        iteration_id !== '0 || iteration_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got valid=%0b id=%0d end=%0b iter=%0d done=%0b expected all 0",
               out_valid, out_v_id, iteration_end, iteration_id, iteration_done);
    end
    rst = 1'b0;
    model_init(20);
    wait_init();
  endtask

  task automatic test_first_scan();
    run_iteration(1'b0, 1'b0, "first_scan");
    check_iter("first_scan_end", 0, 1'b1);
    checks++;
    if (got_q.size() != 5 || got_q[0] != 1 || got_q[4] != 17) begin
      errors++;
      $display("FAIL first_scan_list: got %0d ids expected 1,5,9,13,17", got_q.size());
    end
  endtask

  task automatic test_stale_end();
    send_end(1);
    check_iter("stale_end", 0, 1'b1);
    repeat (2) @(negedge clk);
    check_iter("stale_end_hold", 0, 1'b1);
  endtask

  task automatic test_update_switch();
    drive_upd(5, 1'b1);
    drive_upd(9, 1'b1);
    drive_upd(9, 1'b0);
    drive_upd(13, 1'b1);
    send_end(0);
    check_iter("switch_0", 1, 1'b0);
    model_switch();
    run_iteration(1'b0, 1'b0, "iter1");
  endtask

  task automatic test_empty_done();
    send_end(1);
    check_iter("switch_1", 2, 1'b0);
    model_switch();
    run_iteration(1'b0, 1'b0, "iter2_empty");
    check_iter("iter2_end", 2, 1'b1);
    send_end(2);
    checks++;
    if (iteration_done !== 1'b1 || iteration_id !== ITW'(3) || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL done: got done=%0b iter=%0d valid=%0b expected 1/3/0",
               iteration_done, iteration_id, out_valid);
    end
  endtask

  task automatic test_backpressure();
    int vn;
    vn = 200 + int'($urandom_range(0, 120));
    do_reset(vn, 4);
    for (int it = 0; it < 4; it++) begin
      run_iteration(1'b1, 1'b1, $sformatf("bp_iter%0d", it));
      if (it == 1) begin
        send_end(it + 2);
        check_iter("bp_stale", it, 1'b1);
      end
      send_end(it);
      check_iter($sformatf("bp_switch%0d", it), it + 1, 1'b0);
      model_switch();
    end
    checks++;
    if (iteration_done !== 1'b1) begin
      errors++;
      $display("FAIL bp_done: got %0b expected 1", iteration_done);
    end
  endtask

  task automatic test_reset_mid_scan();
    int accepted = 0;
    int cycles = 0;
    do_reset(20, 3);
    run_iteration(1'b0, 1'b0, "mid_iter0");
    drive_upd(1, 1'b1);
    drive_upd(5, 1'b1);
    drive_upd(9, 1'b1);
    send_end(0);
    check_iter("mid_switch", 1, 1'b0);
    model_switch();
    model_expect();
    out_ready = 1'b1;
    while (accepted < 2 && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (out_valid === 1'b1) begin
        checks++;
        if (int'(out_v_id) != exp_q[accepted]) begin
          errors++;
          $display("FAIL mid_id[%0d]: got %0d expected %0d", accepted, out_v_id, exp_q[accepted]);
        end
        accepted++;
      end
    end
    if (accepted < 2) begin
      checks++;
      errors++;
      $display("FAIL mid_timeout: got %0d ids expected 2", accepted);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || iteration_id !== '0 || iteration_end !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got valid=%0b iter=%0d end=%0b expected 0/0/0",
               out_valid, iteration_id, iteration_end);
    end
    rst = 1'b0;
    model_init(20);
    wait_init();
    run_iteration(1'b0, 1'b0, "mid_restart");
  endtask

  initial begin
    test_reset();
    test_first_scan();
    test_stale_end();
    test_update_switch();
    test_empty_done();
    test_backpressure();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frontier_bitmap_scanner.md
Name: frontier_bitmap_scanner

Overview:
- Per-core active-vertex front end and parametrised successor of the single-core active-vertex reader.
- Holds a ping-pong visited bitmap: the current frontier plus the next frontier written by the backend.
- Scans the current bitmap word by word through a bounded prefetch queue and emits global vertex IDs on a valid/ready stream.
- Runs the per-iteration end handshake with the backend. Word width, bitmap depth, prefetch depth and RAM read latency are all parameters.

Parameters:
- V_ID_WIDTH, 20: vertex ID width.
- ITERATION_WIDTH, 8: iteration counter width.
- CORE_ID, 0: this core's index; the low CORE_NUM_WIDTH bits of every emitted ID.
- CORE_NUM_WIDTH, 5: log2 of the core count.
- WORD_WIDTH, 32: bitmap word width, power of two, 8..256.
- WORD_ADDR_WIDTH, 6: each bank holds 2^WORD_ADDR_WIDTH words.
- PREFETCH_DEPTH, 4: word queue depth, 2..16.
- READ_LATENCY, 2: bitmap read latency in cycles, 1..3.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous reset, active-high.
- vertex_num, input, 32: total vertex count; static while rst is low.
- iteration_num, input, 32: number of iterations to run; static while rst is low.
- upd_valid, input, 1: backend next-frontier write strobe.
- upd_v_id, input, V_ID_WIDTH: global vertex ID to write. Bank bit index = upd_v_id >> CORE_NUM_WIDTH.
- upd_set, input, 1: bit value written into the next bank.
- out_v_id, output, V_ID_WIDTH: active vertex ID.
- out_valid, output, 1: out_v_id is valid.
- out_ready, input, 1: downstream accepts the current ID.
- iteration_end, output, 1: scan of the current iteration is complete.
- backend_iteration_end_valid, input, 1: backend signals that iteration backend_iteration_id has drained.
- backend_iteration_id, input, ITERATION_WIDTH: iteration number the backend end signal refers to.
- iteration_id, output, ITERATION_WIDTH: current iteration.
- iteration_done, output, 1: all iterations finished.

Behaviour:
- words_num = ceil(vertex_num / (WORD_WIDTH << CORE_NUM_WIDTH)), computed in 32-bit arithmetic.
- Bank selection: cur bank = iteration_id[0]; next bank = ~iteration_id[0].
- Reset values: out_valid=0, out_v_id=0, iteration_end=0, iteration_id=0, iteration_done=0, FSM in INIT, queue empty.
- Reset taken mid-operation discards in-flight reads, queue contents and the holding word, then re-enters INIT.
- INIT: one word per cycle at addresses 0..words_num-1; bank0 is written all-ones, bank1 all-zeros. Takes words_num cycles, then goes to SCAN.
- SCAN, read issue: issues word reads at address 0..words_num-1. A read is issued only when in-flight reads + queue occupancy < PREFETCH_DEPTH, so the queue never overflows.
- SCAN, read return: return data enters the queue READ_LATENCY cycles after issue.
- SCAN, holding load: an empty holding register loads from the queue head in the same cycle the head is popped. On the load, the cur bank word at that address is written to zero, leaving the bank clean for iteration+2.
- Emission order: lowest set bit b of holding word w emits out_v_id = ((w*WORD_WIDTH + b) << CORE_NUM_WIDTH) | CORE_ID.
- Out-of-range IDs: an ID ≥ vertex_num clears its bit with no output cycle.
- Handshake: out_valid and out_v_id stay stable until out_valid && out_ready. The bit clears on the accept cycle; the next ID can be valid on the following cycle.
- Throughput: an all-zero word (or all-zero remainder) frees the holding register in 1 cycle.
- SCAN exit: when the last word has been issued, returned and consumed and the holding register is empty, iteration_end goes to 1 on the next cycle; the FSM moves to WAIT_END.
- WAIT_END: iteration_end stays 1 until backend_iteration_end_valid && backend_iteration_id == iteration_id. On that cycle iteration_id increments and iteration_end drops to 0 on the following edge.
- WAIT_END exit: if the incremented iteration_id == iteration_num, go to DONE; otherwise go to SCAN with read address 0.
- DONE: iteration_done=1, out_valid=0. The FSM stays in DONE until rst.
- Updates: upd_valid writes upd_set into the next bank in any state except INIT; updates during INIT are dropped.
- Update and clear in the same cycle target different banks, so no conflict. An update on the iteration-switch cycle uses the pre-switch bank selection.
- Address bounds: an upd_v_id with bit index ≥ words_num*WORD_WIDTH is ignored.
- Zero iterations: iteration_num = 0 after INIT goes directly to DONE.

Optional Feature:
- FRONTIER_COUNT_EN defined: adds output frontier_count [V_ID_WIDTH]. It is a counter of out_valid && out_ready in the current iteration; it holds its value while iteration_end=1 and clears on the iteration_id increment.
- When frontier_count == 0 at SCAN exit, iteration_end is still raised and the handshake proceeds normally.
- FRONTIER_COUNT_EN undefined: the port and counter are absent.

Test Plan:
- Setup for scenarios 1-3: CORE_NUM_WIDTH=2, WORD_WIDTH=8, CORE_ID=1, vertex_num=20, iteration_num=3, out_ready=1.
- 1, first scan: after INIT (1 cycle), emits 1,5,9,13,17 in order. IDs 21..29 are suppressed. Then iteration_end=1, iteration_id=0.
- 2, update and switch: during iteration 0, write upd ids 5 and 13 with set=1, then send backend end for id 0. Expect iteration_id=1 and exactly 5,13 emitted.
- 3, empty iteration and completion: iteration 1 has no updates. After its end handshake, iteration 2 emits nothing and raises iteration_end; its handshake then gives iteration_done=1. With FRONTIER_COUNT_EN, frontier_count is 5, 2, 0 across the three iterations.
- 4, backpressure: out_ready toggles 1-0-0-1 randomly. The ID sequence is unchanged, there are no duplicates, and out_v_id is stable while out_valid && !out_ready.
- 5, stale backend end: backend_iteration_end_valid with backend_iteration_id ≠ iteration_id is ignored; iteration_end stays 1.
- 6, reset mid-scan: rst pulsed after the 2nd ID. Next cycle out_valid=0 and iteration_id=0; the scan restarts at ID 1 after INIT.
